// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, fill level, sticky errors and flush.
// Ports: i_clk/i_rst_n (async active-low), i_flush, i_wr/i_data, i_rd, i_afull_thr,
//   i_aempty_thr, i_clr_err; o_data/o_valid, o_full/o_empty/o_afull/o_aempty,
//   o_fill_level, o_overflow/o_underflow (this cycle), o_ovf_sticky/o_udf_sticky.
// Latency: standard mode 1 cycle from accepted read to o_valid; FWFT head visible
//   the cycle after the write edge. Backpressure: writes at full are rejected unless
//   a read is accepted in the same cycle; reads at empty are always rejected.
module sync_fifo_flex #(
   parameter int G_WIDTH = 8,
   parameter int G_DEPTH = 4,
   parameter int G_FWFT  = 0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_flush,
   input  logic               i_wr,
   input  logic [G_WIDTH-1:0] i_data,
   input  logic               i_rd,
   input  logic [G_DEPTH:0]   i_afull_thr,
   input  logic [G_DEPTH:0]   i_aempty_thr,
   input  logic               i_clr_err,
   output logic [G_WIDTH-1:0] o_data,
   output logic               o_valid,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_afull,
   output logic               o_aempty,
   output logic [G_DEPTH:0]   o_fill_level,
   output logic               o_overflow,
   output logic               o_underflow,
   output logic               o_ovf_sticky,
   output logic               o_udf_sticky
);

   localparam int unsigned  N_ENTRIES = 2**G_DEPTH;
   localparam logic [G_DEPTH:0] FULL_LVL = {1'b1, {G_DEPTH{1'b0}}};

   logic [G_WIDTH-1:0] mem_q [N_ENTRIES];
   logic [G_WIDTH-1:0] mem_d [N_ENTRIES];
   logic [G_DEPTH:0]   wr_ptr_q, wr_ptr_d;
   logic [G_DEPTH:0]   rd_ptr_q, rd_ptr_d;
   logic               ovf_sticky_q, ovf_sticky_d;
   logic               udf_sticky_q, udf_sticky_d;

   logic [G_DEPTH:0]   fill;
   logic [G_DEPTH-1:0] wr_idx, rd_idx;
   logic               full, empty;
   logic               rd_acc, wr_acc;
   logic               rd_do, wr_do;

   // Extra pointer bit distinguishes full from empty; the difference is the occupancy.
   assign fill   = wr_ptr_q - rd_ptr_q;
   assign wr_idx = wr_ptr_q[G_DEPTH-1:0];
   assign rd_idx = rd_ptr_q[G_DEPTH-1:0];
   assign full   = (fill == FULL_LVL);
   assign empty  = (fill == '0);

   // A write at full is allowed when the head is popped in the same cycle:
   // the read sees the old head, the new word lands in that slot at the edge.
   assign rd_acc = i_rd && !empty;
   assign wr_acc = i_wr && (!full || rd_acc);
   // Flush overrides both accepts but the error outputs still report the raw decision.
   assign rd_do  = rd_acc && !i_flush;
   assign wr_do  = wr_acc && !i_flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_do) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_do) rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_do) mem_d[wr_idx] = i_data;
   end

   // Set wins over clear so an error in the clearing cycle is not lost.
   always_comb begin
      ovf_sticky_d = o_overflow  || (ovf_sticky_q && !i_clr_err);
      udf_sticky_d = o_underflow || (udf_sticky_q && !i_clr_err);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ovf_sticky_q <= 1'b0;
         udf_sticky_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ovf_sticky_q <= ovf_sticky_d;
         udf_sticky_q <= udf_sticky_d;
      end
   end

   // Storage is cleared on reset so the FWFT head (and first standard read) is defined.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < N_ENTRIES; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   generate
      if (G_FWFT == 0) begin : g_std
         logic [G_WIDTH-1:0] data_q, data_d;
         logic               valid_q, valid_d;

         // Registered read: data holds between pops, valid is a one-cycle pulse.
         always_comb begin
            data_d  = data_q;
            valid_d = 1'b0;
            if (rd_do) begin
               data_d  = mem_q[rd_idx];
               valid_d = 1'b1;
            end
         end

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               data_q  <= data_d;
               valid_q <= valid_d;
            end
         end

         assign o_data  = data_q;
         assign o_valid = valid_q;
      end else begin : g_fwft
         // Head is presented directly; i_rd acknowledges and advances it.
         assign o_data  = mem_q[rd_idx];
         assign o_valid = !empty;
      end
   endgenerate

   assign o_full       = full;
   assign o_empty      = empty;
   assign o_afull      = (fill >= i_afull_thr);
   assign o_aempty     = (fill <= i_aempty_thr);
   assign o_fill_level = fill;
   assign o_overflow   = i_wr && !wr_acc;
   assign o_underflow  = i_rd && !rd_acc;
   assign o_ovf_sticky = ovf_sticky_q;
   assign o_udf_sticky = udf_sticky_q;

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised successor to the dual-port-pointer synchronous FIFO.
- Adds the following over the previous generation:
  - selectable standard or first-word-fall-through (FWFT) read mode
  - programmable almost-full and almost-empty thresholds
  - fill-level output
  - sticky error flags
  - synchronous flush
  - defined simultaneous read/write at full.
- Sits between streaming producers and consumers inside one clock domain.

Parameters:
- G_WIDTH, 8, data word width in bits.
- G_DEPTH, 4, log2 of entry count; storage holds 2**G_DEPTH words.
- G_FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous flush: empties the FIFO.
- i_wr  in  1  write request.
- i_data  in  G_WIDTH  write data.
- i_rd  in  1  read request (pop).
- i_afull_thr  in  G_DEPTH+1  almost-full threshold.
- i_aempty_thr  in  G_DEPTH+1  almost-empty threshold.
- i_clr_err  in  1  clears the sticky error flags.
- o_data  out  G_WIDTH  read data.
- o_valid  out  1  o_data qualifier.
- o_full  out  1  fill level == 2**G_DEPTH.
- o_empty  out  1  fill level == 0.
- o_afull  out  1  fill level >= i_afull_thr.
- o_aempty  out  1  fill level <= i_aempty_thr.
- o_fill_level  out  G_DEPTH+1  current occupancy.
- o_overflow  out  1  rejected write this cycle (combinational).
- o_underflow  out  1  rejected read this cycle (combinational).
- o_ovf_sticky  out  1  latched overflow.
- o_udf_sticky  out  1  latched underflow.

Behaviour:

Reset (async assert, sync deassert):
- Pointers = 0, o_data = 0, o_valid = 0, stickies = 0.
- Therefore o_empty = 1, o_full = 0, o_fill_level = 0.

Pointers and occupancy:
- Write and read pointers are G_DEPTH+1 bits wide; memory is indexed by pointer[G_DEPTH-1:0].
- Pointers wrap modulo 2**(G_DEPTH+1).
- o_fill_level = wr_ptr - rd_ptr (modulo arithmetic); o_full, o_empty, o_afull and o_aempty are decoded from it.

Accept rules:
- rd_acc = i_rd && !o_empty.
- wr_acc = i_wr && (!o_full || rd_acc): a write at full is accepted when a read is accepted in the same cycle.
- A read at empty is always rejected; there is no write-to-read bypass.
- o_overflow = i_wr && !wr_acc.
- o_underflow = i_rd && !rd_acc.

Simultaneous accepted read and write:
- Fill level is unchanged.
- At full, the write slot equals the head slot. The read returns the old head; the new word is written at the clock edge.

Standard mode (G_FWFT = 0):
- On rd_acc, o_data <= mem[head] and o_valid pulses high for exactly 1 cycle after the accept.
- o_data holds its value when there is no read. Latency is 1 cycle.

FWFT mode (G_FWFT = 1):
- o_data = mem[head] combinationally; o_valid = !o_empty.
- i_rd acts as an acknowledge and pops the head.
- After a write into an empty FIFO, o_valid rises the cycle after the write edge.

Flush:
- Takes priority over i_wr and i_rd in the same cycle.
- Pointers return to 0 and o_valid goes to 0.
- Memory contents, o_data and the stickies are untouched.
- Accept decisions in a flush cycle are suppressed; o_overflow and o_underflow still evaluate per the rules above.

Sticky flags:
- o_ovf_sticky sets on o_overflow; o_udf_sticky sets on o_underflow.
- i_clr_err clears both. If set and clear occur in the same cycle, set wins.

Thresholds:
- Threshold values above 2**G_DEPTH are legal: o_afull never asserts, and o_aempty stays high.
- Threshold changes take effect combinationally.

Test Plan:
- Reset, then write 16 words 0x00..0x0F (G_DEPTH=4) -> o_full=1, o_fill_level=16. A 17th write raises o_overflow and sets o_ovf_sticky; write pointer unchanged.
- From full, assert i_wr=1 (data 0xAA) and i_rd=1 in the same cycle -> write accepted; fill stays 16; in standard mode o_data=0x00 next cycle with a 1-cycle o_valid pulse; 0xAA emerges after 15 further pops.
- Empty FIFO, i_rd=1 and i_wr=1 in the same cycle -> o_underflow=1, read rejected, fill=1. Assert i_clr_err together with a new underflow -> o_udf_sticky remains 1.
- G_FWFT=1: write 0x5A into an empty FIFO -> next cycle o_valid=1 and o_data=0x5A with no read. Pop -> o_valid=0, o_empty=1.
- i_afull_thr=12, i_aempty_thr=3: fill 0->16 -> o_aempty is high for fill 0..3 and o_afull is high for fill 12..16.
- Fill 9 words, assert i_flush together with i_wr -> fill=0, o_empty=1, write dropped, stickies kept. Drive i_rst_n low mid-burst -> all outputs reach reset values immediately, without waiting for a clock edge.
